truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Hardware exhaustive-stimulus engine for combinational gate blocks under test.
//  - Drives every N-bit input vector 0..2^N-1 in order, holding each vector for DWELL cycles.
//  - Samples the DUT's 1-bit response and compares it against a supplied truth table.
//  - Counts mismatches and reports the first failing vector.
//  - Sits between the test harness and the gate under test.
//  - Generalises fixed 3-input timed sweeps to N inputs, with a loop mode and an abort.
// PARAMETERS
//  N        3      input width of gate under test; 1..8
//  DWELL    4      clk cycles each vector is held; >=1
//  ERR_W    N+1    mismatch counter width; saturates at all-ones
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  start          in   1      begin sweep; honoured only in IDLE or DONE
//  loop_en        in   1      sampled on accepted start: 1 = wrap and repeat until abort
//  abort          in   1      return to IDLE at next edge; has priority over everything except reset
//  expected_tt    in   2^N    expected_tt[i] is the golden output for input vector i
//  resp           in   1      DUT output
//  stim           out  N      vector driven to DUT
//  busy           out  1      high in RUN
//  done           out  1      high in DONE (single-shot completion)
//  pass_done      out  1      1-cycle pulse at end of each full pass (both modes)
//  pass           out  1      valid when done: err_count==0
//  err_count      out  ERR_W  mismatches since the last accepted start; saturating
//  first_err_valid out 1      a mismatch has been recorded since the last start
//  first_err_idx  out  N      vector index of the first mismatch
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; stim=0; all other outputs 0.
//  - FSM IDLE -> RUN on start. RUN -> DONE after the last vector with loop=0.
//    DONE -> RUN on start. Any state -> IDLE on abort.
//  - Accepted start:
//    - clears err_count, first_err_valid and first_err_idx;
//    - sets idx=0, stim=0, dwell_cnt=0;
//    - latches loop_en into an internal loop bit.
//  - RUN, each edge:
//    - dwell_cnt increments.
//    - On the edge where dwell_cnt==DWELL-1, resp is sampled (resp reflects stim applied DWELL
//      cycles earlier) and compared with expected_tt[idx].
//    - On mismatch: err_count+1, saturating. If first_err_valid=0, first_err_idx=idx and
//      first_err_valid=1.
//    - On the same edge, idx advances, stim follows idx, and dwell_cnt=0.
//  - Wrap at idx==2^N-1:
//    - pass_done pulses;
//    - if loop=1: idx=0 and RUN continues, with errors accumulating across passes;
//    - else: DONE, done=1, busy=0, pass=(err_count_next==0); stim holds the last vector.
//  - Single pass latency: start edge to done=1 is exactly 2^N*DWELL cycles.
//  - start while busy is ignored. start and abort in the same cycle: abort wins (IDLE).
//  - abort in RUN: no pass_done or done; counters hold for inspection; stim returns to 0.
//  - Mid-sweep reset: same as power-on reset. No partial results are retained.
//  - expected_tt must stay stable while busy; it is not latched.
//  - All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package gate_test_pkg holds:
//    - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//    - localparam NVEC=2^N;
//    - the saturating-increment function, reused by other test engines.
//  - One sub-module, tts_dwell_timer:
//    - clog2(DWELL)-bit counter with clear/enable;
//    - emits `last` when count==DWELL-1.
//  - The top-level contains the FSM, the index/stim register and the checker.
// TESTING (bench: N=3, DWELL=4, clk 10ns)
//  1 Majority DUT, expected_tt=8'b1110_1000, start -> stim 0..7 each held 4 clk;
//    done 32 clk after start; pass=1; err_count=0.
//  2 DUT output forced wrong for vectors 5 and 6 -> err_count=2, first_err_idx=5,
//    first_err_valid=1, pass=0.
//  3 loop_en=1 with the fault from test 2, run 2 passes then abort -> pass_done pulses at
//    32 and 64 clk; err_count=4; state IDLE; done=0.
//  4 start pulsed again at idx=3 while busy -> ignored; sweep finishes at 32 clk unchanged.
//  5 rst_n low at idx=4 -> immediate busy=0, stim=0, err_count=0.
//    After release, start -> clean full sweep.
//  6 N=1, DWELL=1 build, inverter DUT, expected_tt=2'b01 -> done after 2 clk, pass=1;
//    saturation check: N=2, ERR_W=2, all-wrong truth table, loop 2 passes -> err_count=3.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test engines: state encoding, vector count, saturating increment.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned N_MAX = 8;

  // Number of input vectors for an n-input gate (NVEC = 2^n)
  function automatic int unsigned nvec(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Increment that sticks at max_v instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tts_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the final cycle of each dwell.
module tts_dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_c_o
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;

  assign last_c_o = (cnt_q == CW'(DWELL - 1));

  // Count register: clear wins, wraps to zero after the last dwell cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= last_c_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks all 2^N input vectors, checks a 1-bit response,
// counts mismatches and records the first failing vector.
module truth_table_sweeper
  import gate_test_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4,
  parameter int unsigned ERR_W = N + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  loop_en,
  input  logic                  abort,
  input  logic [(1<<N)-1:0]     expected_tt,
  input  logic                  resp,
  output logic [N-1:0]          stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass_done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  first_err_valid,
  output logic [N-1:0]          first_err_idx
);

  localparam int unsigned NVEC    = nvec(N);
  localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

  state_e             state_q, state_d;
  logic [N-1:0]       stim_q, stim_d;
  logic               loop_q, loop_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fev_q, fev_d;
  logic [N-1:0]       fei_q, fei_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pd_q, pd_d;
  logic               pass_q, pass_d;
  logic               dwell_last_c;
  logic               start_ok_c;

  // Dwell timer runs only in RUN; any other state or an abort holds it at zero
  tts_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    ((state_q != ST_RUN) || abort),
    .en_i     (1'b1),
    .last_c_o (dwell_last_c)
  );

  assign start_ok_c = start && (state_q != ST_RUN);

  // Next-state, index advance and response checker
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    loop_d  = loop_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pd_d    = 1'b0;
    pass_d  = pass_q;

    if (abort) begin
      state_d = ST_IDLE;
      stim_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (start_ok_c) begin
      state_d = ST_RUN;
      stim_d  = '0;
      loop_d  = loop_en;
      err_d   = '0;
      fev_d   = 1'b0;
      fei_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else if ((state_q == ST_RUN) && dwell_last_c) begin
      if (resp != expected_tt[stim_q]) begin
        err_d = ERR_W'(sat_inc(32'(err_q), ERR_MAX));
        if (!fev_q) begin
          fev_d = 1'b1;
          fei_d = stim_q;
        end
      end
      if (stim_q == N'(NVEC - 1)) begin
        pd_d = 1'b1;
        if (loop_q) begin
          stim_d = '0;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end else begin
        stim_d = stim_q + N'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      loop_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pd_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pd_q    <= pd_d;
      pass_q  <= pass_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass_done       = pd_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: main N=3/DWELL=4 build plus small N=1 and N=2 builds.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: N=3, DWELL=4, majority gate with injectable faults
  logic       start, loop_en, abort, resp;
  logic [7:0] ett, fault_mask;
  logic [2:0] stim, fei;
  logic       busy, done, pd, pass, fev;
  logic [3:0] err;

  assign resp = ((stim[0] & stim[1]) | (stim[0] & stim[2]) | (stim[1] & stim[2])) ^ fault_mask[stim];

  truth_table_sweeper #(.N(3), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en), .abort(abort),
    .expected_tt(ett), .resp(resp), .stim(stim), .busy(busy), .done(done),
    .pass_done(pd), .pass(pass), .err_count(err), .first_err_valid(fev), .first_err_idx(fei)
  );

  // N=1, DWELL=1 instance driving an inverter
  logic       start1, loop1, abort1, resp1, busy1, done1, pd1, pass1, fev1;
  logic [1:0] ett1, err1;
  logic [0:0] stim1, fei1;

  assign resp1 = ~stim1[0];

  truth_table_sweeper #(.N(1), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .loop_en(loop1), .abort(abort1),
    .expected_tt(ett1), .resp(resp1), .stim(stim1), .busy(busy1), .done(done1),
    .pass_done(pd1), .pass(pass1), .err_count(err1), .first_err_valid(fev1), .first_err_idx(fei1)
  );

  // N=2, ERR_W=2 instance: AND gate against an all-wrong table
  logic       start2, loop2, abort2, resp2, busy2, done2, pd2, pass2, fev2;
  logic [3:0] ett2;
  logic [1:0] stim2, fei2, err2;

  assign resp2 = &stim2;

  truth_table_sweeper #(.N(2), .DWELL(1), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .loop_en(loop2), .abort(abort2),
    .expected_tt(ett2), .resp(resp2), .stim(stim2), .busy(busy2), .done(done2),
    .pass_done(pd2), .pass(pass2), .err_count(err2), .first_err_valid(fev2), .first_err_idx(fei2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until the selected flag is seen; cyc=-1 if the budget runs out
  task automatic wait_flag(input int sel, input int max_c, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_c; i++) begin
      tick();
      if ((sel == 0 && done) || (sel == 1 && pd) || (sel == 2 && done1) || (sel == 3 && pd2)) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int c, c2;
    rst_n = 1'b0;
    start = 0; loop_en = 0; abort = 0; ett = 8'b1110_1000; fault_mask = 8'h00;
    start1 = 0; loop1 = 0; abort1 = 0; ett1 = 2'b01;
    start2 = 0; loop2 = 0; abort2 = 0; ett2 = 4'b0111;

    // Reset state
    #12;
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_flags", 32'({busy, done, pd, pass, fev}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: clean majority sweep, each vector held 4 cycles, done after 32
    start = 1; tick(); start = 0;
    check("t1_busy", 32'({busy, done}), 32'b10);
    check("t1_stim0", 32'(stim), 32'd0);
    for (int k = 1; k < 32; k++) begin
      tick();
      check($sformatf("t1_stim_k%0d", k), 32'({done, stim}), 32'({1'b0, 3'(k / 4)}));
    end
    tick();
    check("t1_done", 32'({busy, done, pd, pass}), 32'b0111);
    check("t1_err", 32'(err), 32'd0);
    check("t1_stim_hold", 32'(stim), 32'd7);
    check("t1_fev", 32'(fev), 32'd0);
    tick();
    check("t1_pd_pulse", 32'({pd, done}), 32'b01);

    // 2: faults on vectors 5 and 6
    fault_mask = 8'b0110_0000;
    start = 1; tick(); start = 0;
    wait_flag(0, 100, c);
    check("t2_latency", 32'(c), 32'd32);
    check("t2_err", 32'(err), 32'd2);
    check("t2_first", 32'({fev, fei}), 32'({1'b1, 3'd5}));
    check("t2_pass", 32'(pass), 32'd0);

    // 3: loop mode, two passes, then abort
    loop_en = 1;
    start = 1; tick(); start = 0; loop_en = 0;
    wait_flag(1, 100, c);
    check("t3_pd1", 32'(c), 32'd32);
    check("t3_busy_loop", 32'({busy, done}), 32'b10);
    wait_flag(1, 100, c2);
    check("t3_pd2", 32'(c2), 32'd32);
    check("t3_err_mid", 32'(err), 32'd4);
    abort = 1; tick(); abort = 0;
    check("t3_idle", 32'({busy, done, pd}), 32'b000);
    check("t3_stim", 32'(stim), 32'd0);
    check("t3_err_hold", 32'(err), 32'd4);
    check("t3_first_hold", 32'({fev, fei}), 32'({1'b1, 3'd5}));

    // 4: start while busy is ignored
    fault_mask = 8'h00;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 13; k++) tick();
    start = 1; tick(); start = 0;
    check("t4_no_restart", 32'(stim), 32'd3);
    wait_flag(0, 100, c);
    check("t4_latency", 32'(c + 14), 32'd32);
    check("t4_result", 32'({pass, err}), 32'({1'b1, 4'd0}));

    // 5: mid-sweep reset at idx 4
    fault_mask = 8'b0000_0011;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 17; k++) tick();
    check("t5_pre_stim", 32'(stim), 32'd4);
    check("t5_pre_err", 32'(err), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_stim", 32'(stim), 32'd0);
    check("t5_rst_err", 32'({fev, err}), 32'd0);
    #3 rst_n = 1'b1;
    fault_mask = 8'h00;
    tick();
    start = 1; tick(); start = 0;
    wait_flag(0, 100, c);
    check("t5_latency", 32'(c), 32'd32);
    check("t5_result", 32'({pass, err}), 32'({1'b1, 4'd0}));

    // 6a: N=1 DWELL=1 inverter
    start1 = 1; tick(); start1 = 0;
    wait_flag(2, 20, c);
    check("t6_n1_latency", 32'(c), 32'd2);
    check("t6_n1_result", 32'({pass1, err1}), 32'({1'b1, 2'd0}));

    // 6b: N=2 ERR_W=2 saturation over two passes
    loop2 = 1;
    start2 = 1; tick(); start2 = 0; loop2 = 0;
    wait_flag(3, 20, c);
    check("t6_n2_pd1", 32'(c), 32'd4);
    wait_flag(3, 20, c);
    check("t6_n2_pd2", 32'(c), 32'd4);
    abort2 = 1; tick(); abort2 = 0;
    check("t6_n2_sat", 32'(err2), 32'd3);
    check("t6_n2_first", 32'({fev2, fei2}), 32'({1'b1, 2'd0}));
    check("t6_n2_idle", 32'({busy2, done2}), 32'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
